// File: rtl/xbar_port_reducer.sv
// rtl/xbar_port_reducer.sv - per-crossbar-port read-modify-write reducer with drain stream
//
// Purpose: folds single-cycle updates from one crossbar output into a local
// vertex-value RAM (unsigned add or unsigned min). A drain pulse flushes the
// RMW pipeline and streams every entry out over valid/ready. The RAM is then
// re-initialised.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   in_id/in_data    update id and value; in_en marks a single-cycle update
//   drain            1-cycle request to dump the partition (honoured only in RUN)
//   ready            high only in RUN; updates outside RUN are dropped
//   out_id/out_data  drain beat: rebuilt global id and stored value
//   out_valid        drain beat valid; out_ready is the downstream accept
//   done             pulse on acceptance of the last drain beat
//   drop_err         sticky flag: an update arrived while ready was low
module xbar_port_reducer #(
   parameter int                    ID_WIDTH   = 32,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    CHUNK_BITS = 20,
   parameter int                    ADDR_BITS  = 10,
   parameter int                    PORT_INDEX = 0,
   parameter int                    OP         = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   in_id,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_en,
   input  logic                  drain,
   output logic                  ready,
   output logic [ID_WIDTH-1:0]   out_id,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  done,
   output logic                  drop_err
);

   localparam int                   DEPTH     = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
   localparam logic [ID_WIDTH-1:0]  PORT_BASE = ID_WIDTH'(PORT_INDEX) << CHUNK_BITS;

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH, ST_DRAIN} state_t;
   state_t state, state_nxt;

   logic [ADDR_BITS-1:0]  init_cnt;

   // RMW pipeline stages: S1 waits for RAM data, W1 writes, W2 only forwards
   logic                  s1_valid, w1_valid, w2_valid;
   logic [ADDR_BITS-1:0]  s1_addr, w1_addr, w2_addr;
   logic [DATA_WIDTH-1:0] s1_data, w1_data, w2_data;
   logic [DATA_WIDTH-1:0] fwd, result;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] ram_q;
   logic [ADDR_BITS-1:0]  ram_raddr, ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  ram_we;

   // Drain side: issue counter, one read in flight, output register plus skid
   logic [ADDR_BITS:0]    issue_cnt;
   logic                  issue, rd_pend;
   logic [ADDR_BITS-1:0]  rd_pend_addr;
   logic                  sk_valid;
   logic [ID_WIDTH-1:0]   sk_id;
   logic [DATA_WIDTH-1:0] sk_data;
   logic                  n_ov, n_sv;
   logic [ID_WIDTH-1:0]   n_oid, n_sid;
   logic [DATA_WIDTH-1:0] n_od, n_sd;
   logic [1:0]            occ;
   logic                  pop, accept, rmw_busy;
   logic                  unused_hi;

   assign unused_hi = ^in_id[ID_WIDTH-1:ADDR_BITS];

   assign ready    = (state == ST_RUN);
   assign accept   = in_en & ready;
   // W2 never writes, so only S1 and W1 must retire before the RAM is read out
   assign rmw_busy = s1_valid | w1_valid;
   assign pop      = out_valid & out_ready;
   assign done     = pop & (state == ST_DRAIN) & (out_id[ADDR_BITS-1:0] == LAST_ADDR);

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_INIT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:  if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
         ST_RUN:   if (drain) state_nxt = ST_FLUSH;
         ST_FLUSH: if (!rmw_busy) state_nxt = ST_DRAIN;
         ST_DRAIN: if (done) state_nxt = ST_INIT;
         default:  state_nxt = ST_INIT;
      endcase
   end

   // Forwarding covers the two writes the sync RAM read cannot yet see
   always_comb begin
      fwd = ram_q;
      if (w1_valid && (w1_addr == s1_addr))      fwd = w1_data;
      else if (w2_valid && (w2_addr == s1_addr)) fwd = w2_data;
      if (OP == 0) result = fwd + s1_data;
      else         result = (fwd < s1_data) ? fwd : s1_data;
   end

   assign ram_raddr = (state == ST_DRAIN) ? issue_cnt[ADDR_BITS-1:0] : in_id[ADDR_BITS-1:0];
   assign ram_we    = (state == ST_INIT) | w1_valid;
   assign ram_waddr = (state == ST_INIT) ? init_cnt : w1_addr;
   assign ram_wdata = (state == ST_INIT) ? INIT_VALUE : w1_data;

   // Read-first: a same-address write in this cycle returns the old word
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_q <= mem[ram_raddr];
   end

   // Issue a read only if its data is guaranteed a slot (out reg or skid)
   assign occ   = {1'b0, out_valid} + {1'b0, sk_valid} + {1'b0, rd_pend};
   assign issue = (state == ST_DRAIN) && !issue_cnt[ADDR_BITS] &&
                  ((occ < 2'd2) || (pop && (occ == 2'd2)));

   always_comb begin
      n_ov  = out_valid;
      n_oid = out_id;
      n_od  = out_data;
      n_sv  = sk_valid;
      n_sid = sk_id;
      n_sd  = sk_data;
      if (pop) begin
         n_ov  = sk_valid;
         n_oid = sk_id;
         n_od  = sk_data;
         n_sv  = 1'b0;
      end
      if (rd_pend) begin
         if (!n_ov) begin
            n_ov  = 1'b1;
            n_oid = PORT_BASE | ID_WIDTH'(rd_pend_addr);
            n_od  = ram_q;
         end else begin
            n_sv  = 1'b1;
            n_sid = PORT_BASE | ID_WIDTH'(rd_pend_addr);
            n_sd  = ram_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         init_cnt     <= '0;
         s1_valid     <= 1'b0;
         s1_addr      <= '0;
         s1_data      <= '0;
         w1_valid     <= 1'b0;
         w1_addr      <= '0;
         w1_data      <= '0;
         w2_valid     <= 1'b0;
         w2_addr      <= '0;
         w2_data      <= '0;
         issue_cnt    <= '0;
         rd_pend      <= 1'b0;
         rd_pend_addr <= '0;
         out_valid    <= 1'b0;
         out_id       <= '0;
         out_data     <= '0;
         sk_valid     <= 1'b0;
         sk_id        <= '0;
         sk_data      <= '0;
         drop_err     <= 1'b0;
      end else begin
         init_cnt     <= (state == ST_INIT) ? init_cnt + ADDR_BITS'(1) : '0;
         s1_valid     <= accept;
         s1_addr      <= in_id[ADDR_BITS-1:0];
         s1_data      <= in_data;
         w1_valid     <= s1_valid;
         w1_addr      <= s1_addr;
         w1_data      <= result;
         w2_valid     <= w1_valid;
         w2_addr      <= w1_addr;
         w2_data      <= w1_data;
         issue_cnt    <= (state == ST_DRAIN) ? issue_cnt + (ADDR_BITS+1)'(issue) : '0;
         rd_pend      <= issue;
         rd_pend_addr <= issue_cnt[ADDR_BITS-1:0];
         out_valid    <= n_ov;
         out_id       <= n_oid;
         out_data     <= n_od;
         sk_valid     <= n_sv;
         sk_id        <= n_sid;
         sk_data      <= n_sd;
         drop_err     <= drop_err | (in_en & ~ready);
      end
   end

endmodule
